dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter between core and DMA load/store ports onto
//               a single-ported data memory, with legality/alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [2:0]  core_funct3,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic        core_rvalid,
    output logic        core_err,
    output logic [31:0] core_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [2:0]  dma_funct3,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic        dma_err,
    output logic [31:0] dma_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    localparam logic c_OWNER_CORE = 1'b0;
    localparam logic c_OWNER_DMA  = 1'b1;

    logic [1:0]  r_state;
    logic        r_ready;
    logic        r_last_grant;
    logic        r_owner;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_core_rdata;
    logic [31:0] r_dma_rdata;
    logic        r_core_err;
    logic        r_dma_err;

    logic        w_can_grant;
    logic        w_gnt_core;
    logic        w_gnt_dma;
    logic        w_legal;
    logic [31:0] w_resp_data;

    // r_ready holds off grants until one full clock cycle has elapsed after reset release
    assign w_can_grant = r_ready && ((r_state == c_IDLE) || (r_state == c_RESP));
    assign w_gnt_core  = w_can_grant && core_req && (!dma_req || (r_last_grant == c_OWNER_DMA));
    assign w_gnt_dma   = w_can_grant && dma_req && !w_gnt_core;

    always_comb begin
        w_legal = 1'b0;
        case (r_funct3)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~r_addr[0];
            3'b010:  w_legal = (r_addr[1:0] == 2'b00);
            3'b100:  w_legal = ~r_we;
            3'b101:  w_legal = ~r_we & ~r_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    assign w_resp_data = (w_legal && !r_we) ? mem_rdata : 32'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_IDLE;
            r_ready      <= 1'b0;
            r_last_grant <= c_OWNER_DMA;
            r_owner      <= c_OWNER_CORE;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_core_rdata <= 32'd0;
            r_dma_rdata  <= 32'd0;
            r_core_err   <= 1'b0;
            r_dma_err    <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            case (r_state)
                c_IDLE, c_RESP: begin
                    if (w_gnt_core || w_gnt_dma) begin
                        r_state      <= c_ACCESS;
                        r_owner      <= w_gnt_dma;
                        r_last_grant <= w_gnt_dma;
                        r_we         <= w_gnt_dma ? dma_we     : core_we;
                        r_funct3     <= w_gnt_dma ? dma_funct3 : core_funct3;
                        r_addr       <= w_gnt_dma ? dma_addr   : core_addr;
                        r_wdata      <= w_gnt_dma ? dma_wdata  : core_wdata;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_ACCESS: begin
                    // Response registers are per port so each holds until its next response
                    r_state <= c_RESP;
                    if (r_owner == c_OWNER_DMA) begin
                        r_dma_rdata <= w_resp_data;
                        r_dma_err   <= ~w_legal;
                    end else begin
                        r_core_rdata <= w_resp_data;
                        r_core_err   <= ~w_legal;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign core_gnt    = w_gnt_core;
    assign dma_gnt     = w_gnt_dma;
    assign core_rvalid = (r_state == c_RESP) && (r_owner == c_OWNER_CORE);
    assign dma_rvalid  = (r_state == c_RESP) && (r_owner == c_OWNER_DMA);
    assign core_rdata  = r_core_rdata;
    assign dma_rdata   = r_dma_rdata;
    assign core_err    = r_core_err;
    assign dma_err     = r_dma_err;

    assign mem_read    = (r_state == c_ACCESS) && w_legal && !r_we;
    assign mem_write   = (r_state == c_ACCESS) && w_legal && r_we;
    assign mem_funct3  = r_funct3;
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter: directed table, corner
//               sequences and randomized traffic against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_req = 0, core_we = 0, dma_req = 0, dma_we = 0;
    logic [2:0]  core_funct3 = 0, dma_funct3 = 0;
    logic [31:0] core_addr = 0, core_wdata = 0, dma_addr = 0, dma_wdata = 0;
    logic [31:0] mem_rdata = 0;
    logic        core_gnt, core_rvalid, core_err, dma_gnt, dma_rvalid, dma_err;
    logic [31:0] core_rdata, dma_rdata;
    logic        mem_read, mem_write;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr, mem_wdata;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_funct3(core_funct3),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_gnt(core_gnt),
        .core_rvalid(core_rvalid), .core_err(core_err), .core_rdata(core_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_funct3(dma_funct3),
        .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
        .dma_rvalid(dma_rvalid), .dma_err(dma_err), .dma_rdata(dma_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_funct3(mem_funct3),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one outstanding transfer with an age (1 = strobe, 2 = response)
    bit          m_ready, m_busy, m_owner, m_we, m_last;
    int          m_age;
    bit [2:0]    m_f3, l_f3;
    bit [31:0]   m_addr, m_wdata, l_addr, l_wdata;
    bit [31:0]   m_rdata [2];
    bit          m_err [2];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit tb_legal(bit we, bit [2:0] f3, bit [31:0] addr);
        bit ok_f3;
        int size;
        ok_f3 = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size  = 1 << int'(f3 & 3'd3);
        return ok_f3 && ((addr % size) == 0);
    endfunction

    task automatic model_reset();
        m_ready = 0; m_busy = 0; m_age = 0; m_last = 1;
        m_owner = 0; m_we = 0; m_f3 = 0; m_addr = 0; m_wdata = 0;
        l_f3 = 0; l_addr = 0; l_wdata = 0;
        m_rdata[0] = 0; m_rdata[1] = 0; m_err[0] = 0; m_err[1] = 0;
    endtask

    task automatic check_all(output bit gc, output bit gd);
        bit can, lg;
        can = m_ready && (!m_busy || m_age == 2);
        gc = 0; gd = 0;
        if (can) begin
            if (core_req && dma_req) begin
                if (m_last) gc = 1; else gd = 1;
            end else if (core_req) gc = 1;
            else if (dma_req) gd = 1;
        end
        lg = m_busy && tb_legal(m_we, m_f3, m_addr);
        chk("core_gnt", core_gnt, gc);
        chk("dma_gnt", dma_gnt, gd);
        chk("mem_read", mem_read, lg && m_age == 1 && !m_we);
        chk("mem_write", mem_write, lg && m_age == 1 && m_we);
        chk("mem_funct3", mem_funct3, l_f3);
        chk("mem_addr", mem_addr, l_addr);
        chk("mem_wdata", mem_wdata, l_wdata);
        chk("core_rvalid", core_rvalid, m_busy && m_age == 2 && !m_owner);
        chk("dma_rvalid", dma_rvalid, m_busy && m_age == 2 && m_owner);
        chk("core_rdata", core_rdata, m_rdata[0]);
        chk("core_err", core_err, m_err[0]);
        chk("dma_rdata", dma_rdata, m_rdata[1]);
        chk("dma_err", dma_err, m_err[1]);
    endtask

    task automatic model_edge(bit gc, bit gd, bit [31:0] mrd);
        bit lg;
        if (m_busy && m_age == 2) m_busy = 0;
        else if (m_busy && m_age == 1) begin
            lg = tb_legal(m_we, m_f3, m_addr);
            m_rdata[m_owner] = (lg && !m_we) ? mrd : 32'd0;
            m_err[m_owner]   = !lg;
            m_age = 2;
        end
        if (gc || gd) begin
            m_busy = 1; m_age = 1; m_owner = gd; m_last = gd;
            m_we    = gd ? dma_we     : core_we;
            m_f3    = gd ? dma_funct3 : core_funct3;
            m_addr  = gd ? dma_addr   : core_addr;
            m_wdata = gd ? dma_wdata  : core_wdata;
            l_f3 = m_f3; l_addr = m_addr; l_wdata = m_wdata;
        end
        m_ready = 1;
    endtask

    task automatic settle(output bit gc, output bit gd);
        #1;
        check_all(gc, gd);
    endtask

    task automatic advance(bit gc, bit gd);
        model_edge(gc, gd, mem_rdata);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive_port(bit p, bit rq, bit we, bit [2:0] f3, bit [31:0] a, bit [31:0] wd);
        if (!p) begin
            core_req = rq; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = wd;
        end else begin
            dma_req = rq; dma_we = we; dma_funct3 = f3; dma_addr = a; dma_wdata = wd;
        end
    endtask

    typedef struct {
        bit        port;
        bit        we;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] mrd;
        bit        exp_rd;
        bit        exp_wr;
        bit [31:0] exp_rdata;
        bit        exp_err;
    } vec_t;

    vec_t vt [10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit gc, gd;
        int grants [$];
        int gcyc [$];
        int nrv;
        bit seen_rv, seen_core_rv, seen_wr;
        bit [31:0] seen_rdata;

        vt[0] = '{0, 0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1, 0, 32'hDEADBEEF, 0};
        vt[1] = '{1, 1, 3'b010, 32'h20,  32'h12345678, 32'h0,        0, 1, 32'h0,        0};
        vt[2] = '{0, 0, 3'b001, 32'h21,  32'h0,        32'h11111111, 0, 0, 32'h0,        1};
        vt[3] = '{0, 1, 3'b100, 32'h40,  32'h55AA55AA, 32'h0,        0, 0, 32'h0,        1};
        vt[4] = '{1, 0, 3'b100, 32'h33,  32'h0,        32'hCAFE00A5, 1, 0, 32'hCAFE00A5, 0};
        vt[5] = '{0, 0, 3'b010, 32'h12,  32'h0,        32'h22222222, 0, 0, 32'h0,        1};
        vt[6] = '{1, 1, 3'b001, 32'h22,  32'h0000BEEF, 32'h0,        0, 1, 32'h0,        0};
        vt[7] = '{0, 0, 3'b011, 32'h80,  32'h0,        32'h33333333, 0, 0, 32'h0,        1};
        vt[8] = '{0, 0, 3'b101, 32'h102, 32'h0,        32'h0000F00D, 1, 0, 32'h0000F00D, 0};
        vt[9] = '{1, 1, 3'b000, 32'h7,   32'h000000EE, 32'h0,        0, 1, 32'h0,        0};

        // Reset with both ports already requesting: nothing may be granted
        model_reset();
        drive_port(0, 1, 0, 3'b010, 32'h100, 32'h0);
        drive_port(1, 1, 0, 3'b010, 32'h200, 32'h0);
        mem_rdata = 32'h0BAD0BAD;
        repeat (2) @(negedge clk);
        #1;
        settle(gc, gd);
        chk("rst_core_gnt", core_gnt, 0);
        chk("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        #1;

        // Continuous contention from reset: alternation starting with the core
        reset = 1'b1;
        nrv = 0;
        for (int i = 0; i < 20; i++) begin
            settle(gc, gd);
            if (core_gnt || dma_gnt) begin
                grants.push_back(dma_gnt ? 1 : 0);
                gcyc.push_back(i);
            end
            if (core_rvalid || dma_rvalid) nrv++;
            advance(gc, gd);
        end
        chk("rr_grant_count", grants.size(), 10);
        chk("rr_rvalid_count", nrv, 9);
        chk("rr_first_grant_cycle", gcyc.size() > 0 ? gcyc[0] : -1, 1);
        for (int i = 0; i < grants.size(); i++) begin
            chk("rr_order", grants[i], i % 2);
            if (i > 0) chk("rr_spacing", gcyc[i] - gcyc[i-1], 2);
        end
        drive_port(0, 0, 0, 0, 0, 0);
        drive_port(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            settle(gc, gd);
            advance(gc, gd);
        end

        // Directed single transfers: gnt at N, strobe at N+1, response at N+2
        foreach (vt[i]) begin
            drive_port(vt[i].port, 1, vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata);
            mem_rdata = vt[i].mrd;
            settle(gc, gd);
            chk("tbl_gnt", vt[i].port ? dma_gnt : core_gnt, 1);
            chk("tbl_other_gnt", vt[i].port ? core_gnt : dma_gnt, 0);
            advance(gc, gd);
            drive_port(vt[i].port, 0, 0, 0, 0, 0);
            settle(gc, gd);
            chk("tbl_mem_read", mem_read, vt[i].exp_rd);
            chk("tbl_mem_write", mem_write, vt[i].exp_wr);
            chk("tbl_mem_addr", mem_addr, vt[i].addr);
            chk("tbl_mem_wdata", mem_wdata, vt[i].wdata);
            advance(gc, gd);
            settle(gc, gd);
            chk("tbl_rvalid", vt[i].port ? dma_rvalid : core_rvalid, 1);
            chk("tbl_other_rvalid", vt[i].port ? core_rvalid : dma_rvalid, 0);
            chk("tbl_rdata", vt[i].port ? dma_rdata : core_rdata, vt[i].exp_rdata);
            chk("tbl_err", vt[i].port ? dma_err : core_err, vt[i].exp_err);
            chk("tbl_strobe_off", mem_read | mem_write, 0);
            advance(gc, gd);
        end

        // Reset in the ACCESS cycle of a core store aborts it
        drive_port(0, 1, 1, 3'b010, 32'h50, 32'hAAAA5555);
        settle(gc, gd);
        chk("abort_gnt", core_gnt, 1);
        advance(gc, gd);
        drive_port(0, 0, 0, 0, 0, 0);
        settle(gc, gd);
        chk("abort_pre_write", mem_write, 1);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_write_drop", mem_write, 0);
        chk("abort_mem_addr", mem_addr, 0);
        model_reset();
        seen_core_rv = 0;
        seen_wr = 0;
        @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            settle(gc, gd);
            if (core_rvalid) seen_core_rv = 1;
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        reset = 1'b1;
        drive_port(1, 1, 0, 3'b010, 32'h60, 32'h0);
        mem_rdata = 32'h0BADF00D;
        seen_rv = 0;
        seen_rdata = 0;
        for (int i = 0; i < 10 && !seen_rv; i++) begin
            settle(gc, gd);
            if (core_rvalid) seen_core_rv = 1;
            if (mem_write) seen_wr = 1;
            if (dma_rvalid) begin
                seen_rv = 1;
                seen_rdata = dma_rdata;
            end
            advance(gc, gd);
            if (gd) drive_port(1, 0, 0, 0, 0, 0);
        end
        chk("abort_no_core_rvalid", seen_core_rv, 0);
        chk("abort_no_write", seen_wr, 0);
        chk("abort_dma_rvalid", seen_rv, 1);
        chk("abort_dma_rdata", seen_rdata, 32'h0BADF00D);

        // Randomized traffic against the transaction model
        gc = 0;
        gd = 0;
        for (int i = 0; i < 400; i++) begin
            if (!core_req || gc)
                drive_port(0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7)),
                           32'($urandom_range(0, 1023)), $urandom);
            if (!dma_req || gd)
                drive_port(1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 1) != 0) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7)),
                           32'($urandom_range(0, 1023)), $urandom);
            mem_rdata = $urandom;
            settle(gc, gd);
            advance(gc, gd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
